// File: rtl/param_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-back / write-allocate cache controller.
// Serves one request at a time. Dirty victims are written back to the backing
// RAM before the line is reused. Hit and miss counters saturate at their maximum.
module param_cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    // state     | meaning
    // IDLE      | ready for a request
    // LOOKUP    | tag compare; hit or clean write miss completes here
    // WRITEBACK | dirty victim written to backing RAM
    // FILL      | line fetched from backing RAM (read miss)
    // RESP      | one-cycle response strobe

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t state, state_nx;

    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              hit_q;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   line_tag;
    logic [DATA_W-1:0]  line_data;
    logic               line_valid;
    logic               line_dirty;
    logic               hit;

    logic               accept;
    logic               line_we;
    logic               line_wdirty;
    logic [DATA_W-1:0]  line_wdata;
    logic               out_load;
    logic [DATA_W-1:0]  out_nx;
    logic               count_hit;
    logic               count_miss;

    assign idx        = addr_q[INDEX_W-1:0];
    assign req_tag    = addr_q[ADDR_W-1:INDEX_W];
    assign line_tag   = tag_mem[idx];
    assign line_data  = data_mem[idx];
    assign line_valid = valid_q[idx];
    assign line_dirty = dirty_q[idx];
    assign hit        = line_valid && (line_tag == req_tag);

    assign req_ready  = (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_hit   = (state == RESP) && hit_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state, line-write, response and backing-RAM request decode.
    always_comb begin
        state_nx    = state;
        line_we     = 1'b0;
        line_wdirty = 1'b0;
        line_wdata  = '0;
        out_load    = 1'b0;
        out_nx      = '0;
        count_hit   = 1'b0;
        count_miss  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                if (accept) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    count_hit = 1'b1;
                    out_load  = 1'b1;
                    if (mode_q) begin
                        line_we     = 1'b1;
                        line_wdirty = 1'b1;
                        line_wdata  = data_q;
                        out_nx      = data_q;
                    end else begin
                        out_nx = line_data;
                    end
                    state_nx = RESP;
                end else begin
                    count_miss = 1'b1;
                    if (line_valid && line_dirty) begin
                        state_nx = WRITEBACK;
                    end else if (!mode_q) begin
                        state_nx = FILL;
                    end else begin
                        // Write-allocate without fetch: the whole word is overwritten.
                        line_we     = 1'b1;
                        line_wdirty = 1'b1;
                        line_wdata  = data_q;
                        out_load    = 1'b1;
                        out_nx      = data_q;
                        state_nx    = RESP;
                    end
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, idx};
                mem_wdata = line_data;
                if (mem_ack) begin
                    if (mode_q) begin
                        line_we     = 1'b1;
                        line_wdirty = 1'b1;
                        line_wdata  = data_q;
                        out_load    = 1'b1;
                        out_nx      = data_q;
                        state_nx    = RESP;
                    end else begin
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    line_we    = 1'b1;
                    line_wdata = mem_rdata;
                    out_load   = 1'b1;
                    out_nx     = mem_rdata;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            mode_q <= mode;
            addr_q <= address;
            data_q <= data;
        end
    end

    // Hit flag for the response, decided on the lookup cycle.
    always_ff @(posedge clk) begin
        if (rst)                  hit_q <= 1'b0;
        else if (state == LOOKUP) hit_q <= hit;
    end

    // Response data register; holds until the next response.
    always_ff @(posedge clk) begin
        if (rst)           out <= '0;
        else if (out_load) out <= out_nx;
    end

    // Valid/dirty bits; reset clears every line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= line_wdirty;
        end
    end

    // Tag and data storage; no reset, contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= line_wdata;
        end
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (count_hit && hit_count != CNT_MAX)   hit_count  <= hit_count + 1'b1;
            if (count_miss && miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_param_cache_ctrl.sv
// Directed bench for param_cache_ctrl with a small backing-RAM responder.
module tb_param_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mode;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] out;
    logic        resp_valid;
    logic        resp_hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  hit_count;
    logic [1:0]  miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    int          ack_delay = 1;
    int          wait_cnt  = 0;
    logic [31:0] fill_data = '0;
    int          mem_req_cycles = 0;
    int          wb_cycles = 0;
    logic [31:0] wb_addr_first = '0;
    logic [31:0] wb_data_first = '0;
    bit          wb_stable = 1'b1;
    logic [31:0] fill_addr = '1;

    param_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(12), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mode       (mode),
        .address    (address),
        .data       (data),
        .out        (out),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Backing RAM: acks after ack_delay cycles of mem_req; records write-back activity.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) mem_req_cycles++;
            if (mem_req && mem_we) begin
                if (wb_cycles == 0) begin
                    wb_addr_first = mem_addr;
                    wb_data_first = mem_wdata;
                end else if (mem_addr !== wb_addr_first || mem_wdata !== wb_data_first) begin
                    wb_stable = 1'b0;
                end
                wb_cycles++;
            end
            if (mem_req && !mem_we) fill_addr = mem_addr;
            if (mem_req && !mem_ack) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fill_data;
                    wait_cnt  = 0;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input bit m, input logic [31:0] a, input logic [31:0] d,
                          output bit h, output logic [31:0] o, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        mode      = m;
        address   = a;
        data      = d;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 40);
        if (!resp_valid) chk("resp_timeout", 64'(lat), 64'd0);
        h = resp_hit;
        o = out;
    endtask

    bit          h;
    logic [31:0] o;
    int          lat;

    initial begin
        rst = 1'b1; req_valid = 1'b0; mode = 1'b0; address = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        rst = 1'b0;

        // Read miss at address 0 -> fill.
        fill_data = 32'd0;
        do_req(1'b0, 32'h0, 32'h0, h, o, lat);
        chk("s1_fill_addr", fill_addr, 32'h0);
        chk("s1_hit", h, 0);
        chk("s1_out", o, 32'h0);
        chk("s1_lat", 64'(lat), 3);
        chk("s1_miss_count", miss_count, 1);

        // Clean write miss: no backing-RAM traffic.
        mem_req_cycles = 0;
        do_req(1'b1, 32'hA7E5FBDC, 32'd526421, h, o, lat);
        chk("s2_w_hit", h, 0);
        chk("s2_w_out", o, 32'd526421);
        chk("s2_w_no_mem", 64'(mem_req_cycles), 0);
        do_req(1'b0, 32'hA7E5FBDC, 32'h0, h, o, lat);
        chk("s2_r_hit", h, 1);
        chk("s2_r_out", o, 32'd526421);
        chk("s2_r_lat", 64'(lat), 2);
        chk("s2_hit_count", hit_count, 1);

        // Dirty victim at index 3036 -> write-back held for 3 cycles.
        ack_delay = 3; wb_cycles = 0; wb_stable = 1'b1;
        do_req(1'b1, 32'h00000BDC, 32'd14528, h, o, lat);
        chk("s3_wb_addr", wb_addr_first, 32'hA7E5FBDC);
        chk("s3_wb_data", wb_data_first, 32'd526421);
        chk("s3_wb_cycles", 64'(wb_cycles), 3);
        chk("s3_wb_stable", wb_stable, 1);
        chk("s3_w_hit", h, 0);
        chk("s3_w_out", o, 32'd14528);
        ack_delay = 1;
        do_req(1'b0, 32'h00000BDC, 32'h0, h, o, lat);
        chk("s3_r_hit", h, 1);
        chk("s3_r_out", o, 32'd14528);
        chk("s3_hit_count", hit_count, 2);
        chk("s3_miss_count", miss_count, 3);

        // Write then write-hit at another index; index 3036 untouched.
        do_req(1'b1, 32'h000F47D1, 32'd25369366, h, o, lat);
        chk("s4_w1_hit", h, 0);
        chk("s4_miss_sat", miss_count, 3);
        do_req(1'b1, 32'h000F47D1, 32'd14528, h, o, lat);
        chk("s4_w2_hit", h, 1);
        do_req(1'b0, 32'h000F47D1, 32'h0, h, o, lat);
        chk("s4_r_hit", h, 1);
        chk("s4_r_out", o, 32'd14528);
        mem_req_cycles = 0;
        do_req(1'b0, 32'h00000BDC, 32'h0, h, o, lat);
        chk("s4_other_hit", h, 1);
        chk("s4_other_out", o, 32'd14528);
        chk("s4_other_no_mem", 64'(mem_req_cycles), 0);
        repeat (3) @(negedge clk);
        chk("s4_out_hold", out, 32'd14528);
        chk("s4_idle_no_resp", resp_valid, 0);

        // Reset in the middle of a fill.
        ack_delay = 10; fill_data = 32'h1234;
        @(negedge clk);
        req_valid = 1'b1; mode = 1'b0; address = 32'h5000; data = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("s6_in_fill", mem_req, 1);
        chk("s6_fill_addr", mem_addr, 32'h5000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s6_mem_req_off", mem_req, 0);
        chk("s6_ready", req_ready, 1);
        chk("s6_out_zero", out, 0);
        chk("s6_hit_count_zero", hit_count, 0);
        rst = 1'b0;
        ack_delay = 1; fill_data = 32'hCAFE;
        do_req(1'b0, 32'h5000, 32'h0, h, o, lat);
        chk("s6_r_hit", h, 0);
        chk("s6_r_out", o, 32'hCAFE);

        // Five hits with a 2-bit counter saturate at 3.
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, 32'h5000, 32'h0, h, o, lat);
            chk("s7_hit", h, 1);
            chk("s7_hit_count", hit_count, (i + 1 > 3) ? 3 : i + 1);
        end
        fill_data = 32'h77;
        do_req(1'b0, 32'hA7E5FBDC, 32'h0, h, o, lat);
        chk("s7_cleared_line_miss", h, 0);
        chk("s7_cleared_line_out", o, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_cache_ctrl.md
PARAM_CACHE_CTRL -- requirements
Module: param_cache_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width in bits, word-addressed.
REQ-002 The block SHALL have parameter DATA_W, default 32: data word width in bits.
REQ-003 The block SHALL have parameter INDEX_W, default 12: line index width, giving 2**INDEX_W one-word lines (4096 by default).
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the hit and miss counters.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-009 The block SHALL have port mode, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port address, input, ADDR_W bits: request address.
REQ-011 The block SHALL have port data, input, DATA_W bits: write data.
REQ-012 The block SHALL have port out, output, DATA_W bits: response data.
REQ-013 The block SHALL have port resp_valid, output, 1 bit: one-cycle response strobe.
REQ-014 The block SHALL have port resp_hit, output, 1 bit: the response was a hit; valid only while resp_valid is high.
REQ-015 The block SHALL have ports mem_req (output, 1 bit), mem_we (output, 1 bit), mem_addr (output, ADDR_W bits) and mem_wdata (output, DATA_W bits): the backing-RAM request.
REQ-016 The block SHALL have ports mem_rdata (input, DATA_W bits) and mem_ack (input, 1 bit): backing-RAM read data and completion strobe.
REQ-017 The block SHALL have ports hit_count and miss_count, outputs, CNT_W bits each: saturating statistics counters.

Function
REQ-018 The cache SHALL be direct-mapped: index = address[INDEX_W-1:0], tag = address[ADDR_W-1:INDEX_W]; each line holds valid, dirty, tag and one data word.
REQ-019 The FSM SHALL have exactly these states: IDLE, LOOKUP, WRITEBACK, FILL, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, which latches mode, address and data and moves the FSM to LOOKUP.
REQ-021 In LOOKUP, a hit (valid && tag match) SHALL: for a read, load out with the line data; for a write, store data in the line, set dirty and load out with data; then go to RESP with resp_hit=1.
REQ-022 In LOOKUP, a miss whose victim line is valid and dirty SHALL go to WRITEBACK.
REQ-023 In LOOKUP, a clean read miss SHALL go to FILL.
REQ-024 In LOOKUP, a clean write miss SHALL install the line as {valid=1, dirty=1, new tag, data}, set out=data and go to RESP; there is no fill (write-allocate, no fetch).
REQ-025 In WRITEBACK, the block SHALL hold mem_req=1, mem_we=1, mem_addr={victim tag, index} and mem_wdata=victim data until mem_ack; on mem_ack a read SHALL go to FILL and a write SHALL install per REQ-024 and go to RESP.
REQ-026 In FILL, the block SHALL hold mem_req=1, mem_we=0, mem_addr=latched address until mem_ack; on mem_ack it SHALL install {valid=1, dirty=0, tag, mem_rdata}, set out=mem_rdata and go to RESP.
REQ-027 In RESP, resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 Hit latency SHALL be resp_valid high in the 2nd cycle after the acceptance edge.
REQ-029 out SHALL hold its last value until the next response.
REQ-030 mem_ack SHALL be ignored outside WRITEBACK and FILL.
REQ-031 The mem_* outputs SHALL be 0 outside WRITEBACK and FILL.
REQ-032 hit_count and miss_count SHALL each increment once per request, on its LOOKUP cycle, and saturate at 2**CNT_W-1 without wrapping.
REQ-033 A request to index i SHALL never affect any line other than i.

Reset
REQ-034 When rst is high at an edge, the block SHALL clear all valid and dirty bits, go to IDLE and zero out, resp_valid, resp_hit, mem_*, hit_count and miss_count; rst SHALL take priority over any request or mem_ack on the same edge.
REQ-035 Reset mid-operation SHALL abandon the transaction without writing any line, and mem_req SHALL be 0 in the cycle after the reset edge.
REQ-036 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 Bench scenario: after reset, read address 0 with mem_rdata=0 -> FILL to mem_addr 0; then resp_valid=1, resp_hit=0, out=0, miss_count=1.
REQ-038 Bench scenario: write 0xA7E5FBDC <- 526421 (clean miss) -> no mem_req; resp_hit=0; then reading 0xA7E5FBDC -> resp_hit=1, out=526421, resp_valid 2 cycles after acceptance.
REQ-039 Bench scenario: write 0x00000BDC <- 14528 (same index 3036, dirty victim) -> WRITEBACK with mem_addr=0xA7E5FBDC and mem_wdata=526421 held across a 3-cycle mem_ack delay; then resp_hit=0, and a subsequent read of 0x00000BDC returns 14528 as a hit.
REQ-040 Bench scenario: write 0x000F47D1 <- 25369366, then write 0x000F47D1 <- 14528 -> the second write is a hit; a read returns 14528; the line at index 3036 is unchanged.
REQ-041 Bench scenario: with CNT_W=2, issue 5 hits -> hit_count=3 (saturated).
REQ-042 Bench scenario: assert rst during FILL -> next cycle mem_req=0 and req_ready=1, and a subsequent read of the same address misses.
